// File: rtl/morse_char_fifo_rx.sv
// Morse receive front end: assembles dot/dash events into character codes and
// queues committed characters and word spaces in a first-word-fall-through FIFO.
module morse_char_fifo_rx #(
    parameter int unsigned MAX_SYMBOLS = 5,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned DW          = 2 * MAX_SYMBOLS,
    parameter int unsigned LW          = $clog2(MAX_SYMBOLS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          writing,
    input  logic          dot,
    input  logic          dash,
    input  logic          interchar,
    input  logic          interword,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [LW-1:0] out_len,
    output logic          out_space,
    output logic          fifo_full,
    output logic          sym_err,
    output logic          drop
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StAccum, StPushSpace} state_e;

    typedef struct packed {
        logic [DW-1:0] code;
        logic [LW-1:0] len;
        logic          space;
    } entry_t;

    state_e        state_q, state_d;
    logic [DW-1:0] code_q, code_d;
    logic [LW-1:0] len_q, len_d;
    logic          bad_q, bad_d;
    logic          last_space_q, last_space_d;
    logic          sym_err_q, sym_err_d;
    logic          drop_q, drop_d;

    logic          boundary;
    logic          char_ok;
    logic          push;
    entry_t        push_entry;

    entry_t        mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          full;
    logic          pop;
    logic          push_accept;
    entry_t        head;

    // Assembly and commit logic; at most one FIFO push per cycle.
    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        len_d        = len_q;
        bad_d        = bad_q;
        last_space_d = last_space_q;
        sym_err_d    = 1'b0;
        boundary     = 1'b0;
        char_ok      = 1'b0;
        push         = 1'b0;
        push_entry   = '0;

        if (writing) begin
            code_d  = '0;
            len_d   = '0;
            bad_d   = 1'b0;
            state_d = StIdle;
        end else begin
            boundary = (interchar || interword) && (state_q != StPushSpace);

            if (state_q == StPushSpace) begin
                push             = 1'b1;
                push_entry.space = 1'b1;
                last_space_d     = 1'b1;
            end

            // Symbols are appended before any same-cycle boundary commits.
            if (dot && dash) begin
                bad_d     = 1'b1;
                sym_err_d = 1'b1;
            end else if (dot || dash) begin
                if (len_q < LW'(MAX_SYMBOLS)) begin
                    for (int k = 0; k < MAX_SYMBOLS; k++) begin
                        if (LW'(k) == len_q) begin
                            code_d[2*k +: 2] = dot ? 2'b01 : 2'b10;
                        end
                    end
                    len_d = len_q + LW'(1);
                end else begin
                    bad_d     = 1'b1;
                    sym_err_d = 1'b1;
                end
            end

            char_ok = (len_d != '0) && !bad_d;

            if (boundary) begin
                if (char_ok) begin
                    push            = 1'b1;
                    push_entry.code = code_d;
                    push_entry.len  = len_d;
                    last_space_d    = 1'b0;
                end else if (interword && !last_space_q) begin
                    push             = 1'b1;
                    push_entry.space = 1'b1;
                    last_space_d     = 1'b1;
                end
                state_d = (interword && char_ok) ? StPushSpace : StIdle;
                code_d  = '0;
                len_d   = '0;
                bad_d   = 1'b0;
            end else begin
                state_d = ((len_d != '0) || bad_d) ? StAccum : StIdle;
            end
        end
    end

    assign full        = (count_q == CW'(FIFO_DEPTH));
    assign out_valid   = (count_q != '0);
    assign pop         = out_valid && out_ready;
    assign push_accept = push && (!full || pop);
    assign drop_d      = push && full && !pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            code_q       <= '0;
            len_q        <= '0;
            bad_q        <= 1'b0;
            last_space_q <= 1'b1;
            sym_err_q    <= 1'b0;
            drop_q       <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            len_q        <= len_d;
            bad_q        <= bad_d;
            last_space_q <= last_space_d;
            sym_err_q    <= sym_err_d;
            drop_q       <= drop_d;
            if (push_accept) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(push_accept) - CW'(pop);
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!reset && push_accept) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign head      = out_valid ? mem_q[rd_ptr_q] : '0;
    assign out_data  = head.code;
    assign out_len   = head.len;
    assign out_space = head.space;
    assign fifo_full = full;
    assign sym_err   = sym_err_q;
    assign drop      = drop_q;

endmodule

// File: doc/morse_char_fifo_rx.md
# morse_char_fifo_rx

- Parametrised Morse receive front end.
- Accumulates dot/dash events from the keyer/decoder into a character code of up to MAX_SYMBOLS symbols.
- Commits a character on an inter-character gap, and a character plus a word-space entry on an inter-word gap.
- Buffers committed entries in a first-word-fall-through FIFO drained with a valid/ready handshake by the display/text side.
- Transmit mode (`writing`) gates off reception.

## Interface
Parameters:
- MAX_SYMBOLS, 5, max symbols per character (≥1); DW = 2*MAX_SYMBOLS, LW = $clog2(MAX_SYMBOLS+1)
- FIFO_DEPTH, 4, entries (power of two, ≥2)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- writing  in  1  transmit mode; 1 = ignore all events and clear assembly
- dot  in  1  one-cycle dot event
- dash  in  1  one-cycle dash event
- interchar  in  1  one-cycle inter-character gap event
- interword  in  1  one-cycle inter-word gap event
- out_ready  in  1  consumer accepts head entry
- out_valid  out  1  FIFO non-empty
- out_data  out  DW  head character code; symbol k at bits [2k+1:2k], 01 = dot, 10 = dash, 00 = unused
- out_len  out  LW  head symbol count (0 for space entry)
- out_space  out  1  head is a word-space entry
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries
- sym_err  out  1  one-cycle pulse: dot and dash together, or symbol overflow
- drop  out  1  one-cycle pulse: push attempted while full and not popping

## Operation
- Assembly registers: code (DW), len (LW), bad (1), last_space (1).
- State machine:
  - IDLE: len == 0, no pending space.
  - ACCUM: len > 0 or bad.
  - PUSH_SPACE: one-cycle state that pushes the deferred space entry.
- Symbol (dot xor dash, writing = 0):
  - len < MAX_SYMBOLS: write 01/10 at slot len, len += 1, go ACCUM.
  - len == MAX_SYMBOLS: symbol dropped, bad = 1, sym_err pulse.
- Dot and dash in the same cycle: both ignored, bad = 1, sym_err pulse.
- Same-cycle symbol and boundary: the symbol is appended first, then the boundary commits the result.
- interchar:
  - len > 0 and !bad: push {code, len, space = 0}, last_space = 0.
  - bad: discard, no push.
  - In all cases, clear code/len/bad and go to IDLE.
- interword:
  - Commit any pending character as for interchar.
  - If a character was pushed this cycle, go to PUSH_SPACE; the space entry is pushed the next cycle.
  - Otherwise push the space entry in this cycle, if !last_space.
  - A pushed space sets last_space = 1.
- Space suppression: last_space resets to 1, so leading and repeated word gaps produce no entries.
- interchar and interword together: treated as interword.
- PUSH_SPACE:
  - Pushes the space entry, then goes to IDLE or ACCUM.
  - Symbol events in this cycle are accepted into the cleared assembly.
  - Boundary events in this cycle are ignored.
- writing = 1:
  - Events ignored; code/len/bad cleared; pending PUSH_SPACE cancelled; state IDLE.
  - FIFO unaffected and still drains.
- FIFO:
  - Pop when out_valid && out_ready.
  - Push when full and popping in the same cycle: accepted.
  - Push when full and not popping: entry lost, drop pulse.
  - A push is never retried.
- Pointers wrap modulo FIFO_DEPTH; count register is $clog2(FIFO_DEPTH+1) bits.
- out_data/out_len/out_space are forced to 0 when out_valid = 0.

## Timing
- Reset values: out_valid 0, out_data 0, out_len 0, out_space 0, fifo_full 0, sym_err 0, drop 0.
- Internal reset state: state IDLE, len 0, bad 0, last_space 1, FIFO empty.
- Reset mid-operation flushes the FIFO and assembly at the next edge.
- Latency: a boundary sampled at edge N makes the entry visible after edge N (out_valid high in cycle N+1).
- A deferred space is visible one cycle after its character.
- Pop at edge N: the next head is visible after edge N. Back-to-back pops sustain one entry per cycle.
- sym_err and drop are registered pulses, high for exactly the cycle after the offending edge.

## Test plan
- Reset, then dot, dash, dot, interchar with out_ready = 0 → one entry: out_data = 0b011001 (low bits), out_len = 3, out_space = 0, out_valid high the cycle after interchar.
- dash, then interword → char entry {10, len 1}, then space entry next cycle. A second interword gives no extra entry. An interword right after reset gives no entry.
- Six dots with MAX_SYMBOLS = 5, then interchar → sym_err on the sixth dot, no entry pushed, FIFO still empty.
- FIFO_DEPTH = 4, out_ready = 0, five characters → fifo_full after the fourth, drop on the fifth. Raise out_ready → entries 1–4 drain in order, one per cycle.
- Dot and dash in the same cycle → sym_err, character discarded on interchar. Assert writing mid-character → assembly cleared and subsequent events ignored while FIFO contents remain.
- Full FIFO with out_ready = 1 and interchar in the same cycle → no drop, count stays 4.
